regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised general-purpose register file for the next core generation.
//  - NUM_RD combinational read ports with write-through bypass from the ex write port; x0 is hardwired to zero.
//  - Debug (jtag) port uses a req/ack handshake. Accesses are arbitrated into idle write cycles, with a starvation-stall fallback.
//  - Optional scoreboard flags read hazards to id.
//  - Sits between id (reads), ex (writeback) and jtag (debug).
// PARAMETERS
//  DATA_W      32  register width
//  ADDR_W      5   address width; NUM_REGS = 2**ADDR_W
//  NUM_RD      2   read ports, 1..4
//  STARVE_MAX  7   WAIT cycles before stall_o is raised, 1..255
// PORTS
//  clk           in   1               core clock, rising edge
//  rst           in   1               reset, asynchronous, active-low
//  we_i          in   1               ex write enable
//  waddr_i       in   ADDR_W          ex write address
//  wdata_i       in   DATA_W          ex write data
//  raddr_i       in   NUM_RD*ADDR_W   read addresses, port k at [k*ADDR_W +: ADDR_W]
//  rdata_o       out  NUM_RD*DATA_W   read data, port k at [k*DATA_W +: DATA_W]
//  dbg_req_i     in   1               debug request, level, held until dbg_ack_o
//  dbg_we_i      in   1               1 = write, 0 = read; stable while req high
//  dbg_addr_i    in   ADDR_W          debug address; stable while req high
//  dbg_wdata_i   in   DATA_W          debug write data; stable while req high
//  dbg_ack_o     out  1               one-cycle completion pulse
//  dbg_rdata_o   out  DATA_W          debug read data, valid with ack, held until next ack
//  stall_o       out  1               asks core to suppress we_i (starvation)
//  issue_i       in   1               id issues instr with destination issue_addr_i
//  issue_addr_i  in   ADDR_W          destination register of issued instr
//  busy_o        out  NUM_RD          read port k hazard (pending write)
// BEHAVIOUR
//  Reset (rst=0, async): dbg_ack_o=0, dbg_rdata_o=0, stall_o=0, busy bits=0, FSM=IDLE, starve cnt=0.
//  - Register array is not reset. Array contents survive reset mid-operation.
//  Reads (comb), per port k, in priority order:
//  - addr==0 -> 0.
//  - else we_i && waddr_i==addr -> wdata_i.
//  - else array value.
//  - Debug writes are never bypassed; they are visible the cycle after ACCESS.
//  Ex write: at posedge if we_i && waddr_i!=0.
//  Debug FSM (registered): IDLE, WAIT, STALL, ACK.
//  - IDLE: dbg_req_i=1 -> WAIT, cnt=0.
//  - WAIT:
//    - we_i=0 -> perform access at this edge, -> ACK.
//    - else cnt++; cnt==STARVE_MAX-1 -> STALL.
//  - STALL: stall_o=1.
//    - we_i=0 -> access, -> ACK.
//    - we_i=1 (protocol violation) -> ex write wins, stay in STALL.
//  - ACK: dbg_ack_o=1 for exactly this cycle, stall_o=0, -> IDLE.
//    - Req still high in the following IDLE cycle starts a new transaction.
//  - Access:
//    - write: array[dbg_addr_i]<=dbg_wdata_i unless addr==0.
//    - read: dbg_rdata_o<=array[dbg_addr_i] (0 for addr 0).
//  - Minimum latency: req high at cycle 0 -> ack high at cycle 2.
//  - Ex write and debug access never occur at the same edge.
// CONFIGURATION
//  RF_SCOREBOARD_EN defined:
//  - busy[NUM_REGS] bits.
//  - issue_i && issue_addr_i!=0 sets busy[issue_addr_i].
//  - we_i clears busy[waddr_i].
//  - Set and clear of the same address at the same edge -> set wins.
//  - busy_o[k] = busy[raddr_k] && !(we_i && waddr_i==raddr_k); 0 for raddr 0.
//  - Debug writes do not alter busy.
//  RF_SCOREBOARD_EN undefined: no busy storage, busy_o tied 0, issue_i/issue_addr_i ignored.
// TESTING
//  1. Write 0xDEADBEEF to x5 via we_i, read x5 on both ports same cycle -> bypass 0xDEADBEEF; next cycle array value 0xDEADBEEF.
//  2. we_i=1 waddr=0 wdata=0x1234; read x0 -> 0 on all ports, same and next cycle.
//  3. dbg write x7=0xA5A5A5A5 with we_i=0 -> ack at cycle 2; port0 reads x7=0xA5A5A5A5 at cycle 3. Then dbg read x7 -> dbg_rdata_o=0xA5A5A5A5 with ack.
//  4. dbg req with we_i=1 continuously, STARVE_MAX=7 -> stall_o rises after 7 WAIT cycles; drop we_i -> ack next cycle, stall_o falls with ack.
//  5. Assert rst in STALL -> stall_o=0, dbg_ack_o=0 immediately; register x7 still 0xA5A5A5A5 after release.
//  6. (RF_SCOREBOARD_EN) issue x3; read x3 -> busy_o=1; we_i x3 same cycle as read -> busy_o=0. Issue+write x3 same edge -> busy stays 1.

Source files
------------

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with bypassed reads, arbitrated debug port and optional hazard scoreboard
// Optional feature macro: RF_SCOREBOARD_EN (per-register busy tracking driving busy_o).
module regfile_mp #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int NUM_RD     = 2,
    parameter int STARVE_MAX = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we_i,
    input  logic [ADDR_W-1:0]        waddr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic [NUM_RD*ADDR_W-1:0] raddr_i,
    output logic [NUM_RD*DATA_W-1:0] rdata_o,
    input  logic                     dbg_req_i,
    input  logic                     dbg_we_i,
    input  logic [ADDR_W-1:0]        dbg_addr_i,
    input  logic [DATA_W-1:0]        dbg_wdata_i,
    output logic                     dbg_ack_o,
    output logic [DATA_W-1:0]        dbg_rdata_o,
    output logic                     stall_o,
    input  logic                     issue_i,
    input  logic [ADDR_W-1:0]        issue_addr_i,
    output logic [NUM_RD-1:0]        busy_o
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam logic [7:0] CNT_LAST = 8'(STARVE_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_STALL = 2'd2,
        S_ACK   = 2'd3
    } dbg_state_t;

    dbg_state_t state, state_nxt;
    logic [7:0]        starve_cnt;
    logic              dbg_go;
    logic [DATA_W-1:0] mem [NUM_REGS];
    logic [ADDR_W-1:0] ra [NUM_RD];
    logic [DATA_W-1:0] rd [NUM_RD];

    // Debug accesses only land on edges where the ex port is not writing.
    assign dbg_go = ((state == S_WAIT) || (state == S_STALL)) && !we_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (dbg_req_i) state_nxt = S_WAIT;
            S_WAIT: begin
                if (!we_i) begin
                    state_nxt = S_ACK;
                end else if (starve_cnt == CNT_LAST) begin
                    state_nxt = S_STALL;
                end
            end
            S_STALL: if (!we_i) state_nxt = S_ACK;
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        dbg_ack_o = (state == S_ACK);
        stall_o   = (state == S_STALL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt  <= '0;
            dbg_rdata_o <= '0;
        end else begin
            if (state == S_IDLE) begin
                starve_cnt <= '0;
            end else if ((state == S_WAIT) && we_i) begin
                starve_cnt <= starve_cnt + 8'd1;
            end
            if (dbg_go && !dbg_we_i) begin
                dbg_rdata_o <= (dbg_addr_i == '0) ? '0 : mem[dbg_addr_i];
            end
        end
    end

    // Storage is deliberately left out of reset so contents survive a mid-run reset.
    always_ff @(posedge clk) begin
        if (we_i && (waddr_i != '0)) begin
            mem[waddr_i] <= wdata_i;
        end else if (dbg_go && dbg_we_i && (dbg_addr_i != '0)) begin
            mem[dbg_addr_i] <= dbg_wdata_i;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        assign ra[k] = raddr_i[k*ADDR_W +: ADDR_W];

        always_comb begin
            if (ra[k] == '0) begin
                rd[k] = '0;
            end else if (we_i && (waddr_i == ra[k])) begin
                rd[k] = wdata_i;
            end else begin
                rd[k] = mem[ra[k]];
            end
        end

        assign rdata_o[k*DATA_W +: DATA_W] = rd[k];
    end

`ifdef RF_SCOREBOARD_EN
    logic [NUM_REGS-1:0] busy, busy_nxt;

    // A same-edge issue to the register being written back marks it busy again.
    always_comb begin
        busy_nxt = busy;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (issue_i && (issue_addr_i == ADDR_W'(i))) begin
                busy_nxt[i] = 1'b1;
            end else if (we_i && (waddr_i == ADDR_W'(i))) begin
                busy_nxt[i] = 1'b0;
            end
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_busy
        assign busy_o[k] = (ra[k] != '0) && busy[ra[k]] && !(we_i && (waddr_i == ra[k]));
    end
`else
    logic unused_issue;

    assign unused_issue = ^{issue_i, issue_addr_i};
    assign busy_o       = '0;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed scoreboard bench for regfile_mp
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             we_i;
    logic [AW-1:0]    waddr_i;
    logic [DW-1:0]    wdata_i;
    logic [NR*AW-1:0] raddr_i;
    logic [NR*DW-1:0] rdata_o;
    logic             dbg_req_i;
    logic             dbg_we_i;
    logic [AW-1:0]    dbg_addr_i;
    logic [DW-1:0]    dbg_wdata_i;
    logic             dbg_ack_o;
    logic [DW-1:0]    dbg_rdata_o;
    logic             stall_o;
    logic             issue_i;
    logic [AW-1:0]    issue_addr_i;
    logic [NR-1:0]    busy_o;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .STARVE_MAX(7)) dut (
        .clk(clk), .rst(rst),
        .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .raddr_i(raddr_i), .rdata_o(rdata_o),
        .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
        .dbg_wdata_i(dbg_wdata_i), .dbg_ack_o(dbg_ack_o), .dbg_rdata_o(dbg_rdata_o),
        .stall_o(stall_o), .issue_i(issue_i), .issue_addr_i(issue_addr_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        exp_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty observed=%h expected=<nothing queued>", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic set_raddr(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        raddr_i = {a1, a0};
    endtask

    // Ex port held idle, so every transaction should ack two cycles after req.
    task automatic dbg_txn(input string tag, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [DW-1:0] exp_rd);
        int lat;
        we_i        = 1'b0;
        dbg_we_i    = w;
        dbg_addr_i  = a;
        dbg_wdata_i = d;
        dbg_req_i   = 1'b1;
        sb_push({tag, "_lat"}, 32'd2);
        if (!w) sb_push({tag, "_rdata"}, exp_rd);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!dbg_ack_o && lat < 20);
        sb_check(32'(lat));
        if (!w) sb_check(dbg_rdata_o);
        dbg_req_i = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b0;
        we_i = 1'b0; waddr_i = '0; wdata_i = '0; raddr_i = '0;
        dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = '0; dbg_wdata_i = '0;
        issue_i = 1'b0; issue_addr_i = '0;
        #12;
        sb_push("rst_ack", 32'd0);   sb_check(32'(dbg_ack_o));
        sb_push("rst_rdata", 32'd0); sb_check(dbg_rdata_o);
        sb_push("rst_stall", 32'd0); sb_check(32'(stall_o));
        sb_push("rst_busy", 32'd0);  sb_check(32'(busy_o));
        rst = 1'b1;
        tick();

        // Bypass then array read of x5
        we_i = 1'b1; waddr_i = 5'd5; wdata_i = 32'hDEADBEEF;
        set_raddr(5'd5, 5'd5);
        #1;
        sb_push("byp_p0", 32'hDEADBEEF); sb_check(rdata_o[0 +: DW]);
        sb_push("byp_p1", 32'hDEADBEEF); sb_check(rdata_o[DW +: DW]);
        tick();
        we_i = 1'b0; wdata_i = 32'h0;
        #1;
        sb_push("arr_p0", 32'hDEADBEEF); sb_check(rdata_o[0 +: DW]);
        sb_push("arr_p1", 32'hDEADBEEF); sb_check(rdata_o[DW +: DW]);

        // x0 stays zero even when targeted
        we_i = 1'b1; waddr_i = 5'd0; wdata_i = 32'h1234;
        set_raddr(5'd0, 5'd0);
        #1;
        sb_push("x0_same_p0", 32'd0); sb_check(rdata_o[0 +: DW]);
        sb_push("x0_same_p1", 32'd0); sb_check(rdata_o[DW +: DW]);
        tick();
        we_i = 1'b0;
        #1;
        sb_push("x0_next_p0", 32'd0); sb_check(rdata_o[0 +: DW]);
        sb_push("x0_next_p1", 32'd0); sb_check(rdata_o[DW +: DW]);

        // Debug write and read-back of x7
        dbg_txn("dbg_wr_x7", 1'b1, 5'd7, 32'hA5A5A5A5, 32'h0);
        set_raddr(5'd7, 5'd5);
        #1;
        sb_push("dbg_x7_p0", 32'hA5A5A5A5); sb_check(rdata_o[0 +: DW]);
        dbg_txn("dbg_rd_x7", 1'b0, 5'd7, 32'h0, 32'hA5A5A5A5);
        dbg_txn("dbg_rd_x0", 1'b0, 5'd0, 32'h0, 32'h0);

        // Starvation: continuous ex writes force STALL after 7 WAIT cycles
        we_i = 1'b1; waddr_i = 5'd9; wdata_i = 32'h99;
        dbg_we_i = 1'b1; dbg_addr_i = 5'd8; dbg_wdata_i = 32'h11112222; dbg_req_i = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) tick();
        sb_push("starve_pre", 32'd0); sb_check(32'(stall_o));
        tick();
        sb_push("starve_stall", 32'd1); sb_check(32'(stall_o));
        sb_push("stall_no_ack", 32'd0); sb_check(32'(dbg_ack_o));
        we_i = 1'b0;
        tick();
        sb_push("stall_ack", 32'd1);   sb_check(32'(dbg_ack_o));
        sb_push("stall_fall", 32'd0);  sb_check(32'(stall_o));
        dbg_req_i = 1'b0;
        tick();
        sb_push("ack_pulse", 32'd0); sb_check(32'(dbg_ack_o));
        set_raddr(5'd8, 5'd9);
        #1;
        sb_push("x8_dbg", 32'h11112222); sb_check(rdata_o[0 +: DW]);
        sb_push("x9_ex", 32'h99);        sb_check(rdata_o[DW +: DW]);

        // Async reset while stalled
        we_i = 1'b1; waddr_i = 5'd9; wdata_i = 32'h99;
        dbg_we_i = 1'b0; dbg_addr_i = 5'd7; dbg_req_i = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        sb_push("rst_pre_stall", 32'd1); sb_check(32'(stall_o));
        rst = 1'b0;
        #1;
        sb_push("rst_stall_clr", 32'd0); sb_check(32'(stall_o));
        sb_push("rst_ack_clr", 32'd0);   sb_check(32'(dbg_ack_o));
        dbg_req_i = 1'b0; we_i = 1'b0;
        #3;
        rst = 1'b1;
        tick();
        set_raddr(5'd7, 5'd5);
        #1;
        sb_push("x7_survive", 32'hA5A5A5A5); sb_check(rdata_o[0 +: DW]);
        sb_push("x5_survive", 32'hDEADBEEF); sb_check(rdata_o[DW +: DW]);

`ifdef RF_SCOREBOARD_EN
        issue_i = 1'b1; issue_addr_i = 5'd3;
        tick();
        issue_i = 1'b0;
        set_raddr(5'd3, 5'd0);
        #1;
        sb_push("busy_set", 32'd1); sb_check(32'(busy_o[0]));
        sb_push("busy_x0", 32'd0);  sb_check(32'(busy_o[1]));
        we_i = 1'b1; waddr_i = 5'd3; wdata_i = 32'h33;
        #1;
        sb_push("busy_wb_mask", 32'd0); sb_check(32'(busy_o[0]));
        tick();
        we_i = 1'b0;
        #1;
        sb_push("busy_cleared", 32'd0); sb_check(32'(busy_o[0]));
        issue_i = 1'b1; issue_addr_i = 5'd3;
        we_i = 1'b1; waddr_i = 5'd3; wdata_i = 32'h44;
        tick();
        issue_i = 1'b0; we_i = 1'b0;
        #1;
        sb_push("busy_set_wins", 32'd1); sb_check(32'(busy_o[0]));
`else
        issue_i = 1'b1; issue_addr_i = 5'd3;
        set_raddr(5'd3, 5'd3);
        tick();
        issue_i = 1'b0;
        #1;
        sb_push("busy_tied0", 32'd0); sb_check(32'(busy_o));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
